// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encodings,
// default vectors, redirect-source encoding and the sequential-PC helper.
// Pure declarations; no logic, latency or backpressure of its own.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

   // Fetch FSM states
   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   // Redirect source, in priority order
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_EXC  = 2'd1;
   localparam logic [1:0] SRC_BR   = 2'd2;
   localparam logic [1:0] SRC_JMP  = 2'd3;

   // Sequential next PC; wraps naturally at 2^32
   function automatic logic [31:0] seq_pc(input logic [31:0] p);
      return p + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority mux over the redirect sources: exception, then branch, then jump.
// Purely combinational, zero latency.
// No flow control; the result is consumed in the same cycle.
module redirect_sel
   import fetch_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic        exc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   output logic        redir,
   output logic [31:0] target,
   output logic [1:0]  src
);

   // Highest-priority active source wins
   always_comb begin
      redir  = exc | br_taken | jmp;
      target = '0;
      src    = SRC_NONE;
      if (exc) begin
         target = EXC_VEC;
         src    = SRC_EXC;
      end else if (br_taken) begin
         target = br_target;
         src    = SRC_BR;
      end else if (jmp) begin
         target = jmp_target;
         src    = SRC_JMP;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register, runs imem req/ack, buffers one instruction.
// Ack in cycle N presents the instruction in N+1; back-to-back acks give 1 instr/cycle.
// New fetches issue only when the buffer is empty or being drained (stall_d low).
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] npc,
   output logic        pc_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_d,
   input  logic        exc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        pend_vld;
   logic        pend_exc;
   logic [31:0] pend_target;
   logic        redir;
   logic [31:0] redir_target;
   logic [1:0]  redir_src;
   logic        can_issue;
   logic        done;
   logic        keep;
   logic        pend_wr;

   redirect_sel #(.EXC_VEC(EXC_VEC)) u_redirect_sel (
      .exc        (exc),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .redir      (redir),
      .target     (redir_target),
      .src        (redir_src)
   );

   assign can_issue = !instr_valid || !stall_d;
   assign imem_req  = (state == ST_WAIT) || ((state == ST_IDLE) && can_issue && !redir);
   assign imem_addr = pc;
   assign done      = imem_req && imem_ack;
   // A completed fetch is only useful if nothing has redirected the stream meanwhile
   assign keep      = done && !redir && !pend_vld;
   // A pending exception can only be displaced by another exception
   assign pend_wr   = (state == ST_WAIT) && !imem_ack && redir &&
                      (!(pend_vld && pend_exc) || (redir_src == SRC_EXC));

   // PC register control: sequential advance, live redirect, or deferred redirect
   always_comb begin
      npc   = seq_pc(pc);
      pc_en = 1'b0;
      if ((state == ST_IDLE) && redir) begin
         pc_en = 1'b1;
         npc   = redir_target;
      end else if (done) begin
         pc_en = 1'b1;
         if (redir) begin
            npc = redir_target;
         end else if (pend_vld) begin
            npc = pend_target;
         end
      end
   end

   // Next-state logic; BOOT ignores any stray ack since no request is out
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: state_nxt = ST_IDLE;
         ST_IDLE: if (imem_req && !imem_ack) state_nxt = ST_WAIT;
         ST_WAIT: if (imem_ack) state_nxt = ST_IDLE;
         default: state_nxt = ST_BOOT;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Redirect deferred while a fetch is outstanding; resolved on the ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_vld    <= 1'b0;
         pend_exc    <= 1'b0;
         pend_target <= RESET_PC;
      end else if (done) begin
         pend_vld <= 1'b0;
         pend_exc <= 1'b0;
      end else if (pend_wr) begin
         pend_vld    <= 1'b1;
         pend_exc    <= (redir_src == SRC_EXC);
         pend_target <= redir_target;
      end
   end

   // One-entry output buffer: refill on a kept fetch, flush on redirect, drain when taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
      end else if (keep) begin
         instr_valid <= 1'b1;
         instr       <= imem_rdata;
         instr_pc    <= pc;
      end else if (redir && (state != ST_BOOT)) begin
         instr_valid <= 1'b0;
      end else if (instr_valid && !stall_d) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a PC-register model, a memory model and
// an instruction scoreboard filled when a kept fetch is acked and drained when
// decode takes the buffered instruction.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        pc_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall_d;
   logic        exc;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;
   exp_t sb_q[$];

   fetch_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .npc        (npc),
      .pc_en      (pc_en),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .stall_d    (stall_d),
      .exc        (exc),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_F00D;
   endfunction

   // PC register model
   always @(posedge clk or posedge rst) begin
      if (rst) pc <= 32'h0000_3000;
      else if (pc_en) pc <= npc;
   end

   // Instruction memory model: word is a fixed function of the address
   assign imem_rdata = mem_word(imem_addr);

   task automatic clear_inputs();
      imem_ack   = 1'b0;
      stall_d    = 1'b0;
      exc        = 1'b0;
      br_taken   = 1'b0;
      br_target  = '0;
      jmp        = 1'b0;
      jmp_target = '0;
   endtask

   // Called at the negedge: drain the scoreboard if decode takes an instruction, then advance
   task automatic end_cycle();
      exp_t e;
      if (!rst && instr_valid && !stall_d) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: got instr_pc %h instr %h, want no instruction", instr_pc, instr);
         end else begin
            e = sb_q.pop_front();
            if (instr_pc !== e.pc || instr !== e.word)
               $display("FAIL sb_instr: got pc %h instr %h, want pc %h instr %h", instr_pc, instr, e.pc, e.word);
            else n_pass++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one cycle into IDLE with pc = reset vector
   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      sb_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #2;
      n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else n_pass++;
      n_checks++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else n_pass++;
      n_checks++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
      n_checks++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en: got %b want 0", pc_en); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b want 0", imem_req); else n_pass++;
      end_cycle();
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
         $display("FAIL first_req: got req %b addr %h want 1 3000", imem_req, imem_addr); else n_pass++;
      end_cycle();
   endtask

   task automatic test_stream();
      logic [31:0] a;
      do_reset();
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h3000 + 32'(4 * i);
         @(negedge clk);
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== a)
            $display("FAIL stream_addr: got req %b addr %h want 1 %h", imem_req, imem_addr, a); else n_pass++;
         n_checks++; if (pc_en !== 1'b1 || npc !== a + 32'd4)
            $display("FAIL stream_npc: got pc_en %b npc %h want 1 %h", pc_en, npc, a + 32'd4); else n_pass++;
         sb_q.push_back({a, mem_word(a)});
         end_cycle();
      end
      imem_ack = 1'b0;
      @(negedge clk);
      end_cycle();
   endtask

   task automatic test_stall();
      int pulses;
      logic [31:0] a;
      do_reset();
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h3000 + 32'(4 * i);
         @(negedge clk);
         sb_q.push_back({a, mem_word(a)});
         end_cycle();
      end
      stall_d = 1'b1;
      pulses  = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (pc_en === 1'b1) pulses++;
         n_checks++; if (instr_pc !== 32'h3008 || instr !== mem_word(32'h3008) || instr_valid !== 1'b1)
            $display("FAIL stall_hold: got v %b pc %h instr %h want 1 3008 %h", instr_valid, instr_pc, instr, mem_word(32'h3008)); else n_pass++;
         n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else n_pass++;
         end_cycle();
      end
      n_checks++; if (pulses > 1) $display("FAIL stall_pc_en: got %0d pulses want at most 1", pulses); else n_pass++;
      stall_d = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C)
         $display("FAIL stall_resume: got req %b addr %h want 1 300c", imem_req, imem_addr); else n_pass++;
      sb_q.push_back({32'h300C, mem_word(32'h300C)});
      end_cycle();
      imem_ack = 1'b0;
      @(negedge clk);
      end_cycle();
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_ack = 1'b1;
      @(negedge clk); sb_q.push_back({32'h3000, mem_word(32'h3000)}); end_cycle();
      @(negedge clk); sb_q.push_back({32'h3004, mem_word(32'h3004)}); end_cycle();
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         br_taken  = (i == 1);
         br_target = 32'h3100;
         @(negedge clk);
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || pc_en !== 1'b0)
            $display("FAIL wait_hold: got req %b addr %h pc_en %b want 1 3008 0", imem_req, imem_addr, pc_en); else n_pass++;
         end_cycle();
      end
      br_taken = 1'b0;
      imem_ack = 1'b1;
      @(negedge clk);
      n_checks++; if (pc_en !== 1'b1 || npc !== 32'h3100)
         $display("FAIL wait_redir: got pc_en %b npc %h want 1 3100", pc_en, npc); else n_pass++;
      end_cycle();
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100 || instr_valid !== 1'b0)
         $display("FAIL wait_next: got req %b addr %h valid %b want 1 3100 0", imem_req, imem_addr, instr_valid); else n_pass++;
      sb_q.push_back({32'h3100, mem_word(32'h3100)});
      end_cycle();
      imem_ack = 1'b0;
      @(negedge clk);
      end_cycle();
   endtask

   task automatic test_priority();
      do_reset();
      exc = 1'b1; br_taken = 1'b1; br_target = 32'h3100; jmp = 1'b1; jmp_target = 32'h3200;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b1 || npc !== 32'h4180)
         $display("FAIL prio_all: got req %b pc_en %b npc %h want 0 1 4180", imem_req, pc_en, npc); else n_pass++;
      end_cycle();
      exc = 1'b0; br_taken = 1'b0; jmp = 1'b0; imem_ack = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4180)
         $display("FAIL prio_fetch: got req %b addr %h want 1 4180", imem_req, imem_addr); else n_pass++;
      sb_q.push_back({32'h4180, mem_word(32'h4180)});
      end_cycle();
      imem_ack = 1'b0; br_taken = 1'b1; jmp = 1'b1;
      @(negedge clk);
      n_checks++; if (pc_en !== 1'b1 || npc !== 32'h3100)
         $display("FAIL prio_br_jmp: got pc_en %b npc %h want 1 3100", pc_en, npc); else n_pass++;
      end_cycle();
      br_taken = 1'b0; jmp = 1'b0;
   endtask

   task automatic test_pending_exc();
      do_reset();
      @(negedge clk); end_cycle();
      exc = 1'b1;
      @(negedge clk);
      n_checks++; if (pc_en !== 1'b0 || imem_addr !== 32'h3000)
         $display("FAIL pend_exc_hold: got pc_en %b addr %h want 0 3000", pc_en, imem_addr); else n_pass++;
      end_cycle();
      exc = 1'b0; jmp = 1'b1; jmp_target = 32'h3200;
      @(negedge clk);
      n_checks++; if (pc_en !== 1'b0 || imem_req !== 1'b1)
         $display("FAIL pend_jmp_hold: got pc_en %b req %b want 0 1", pc_en, imem_req); else n_pass++;
      end_cycle();
      jmp = 1'b0; imem_ack = 1'b1;
      @(negedge clk);
      n_checks++; if (pc_en !== 1'b1 || npc !== 32'h4180)
         $display("FAIL pend_exc_wins: got pc_en %b npc %h want 1 4180", pc_en, npc); else n_pass++;
      end_cycle();
      imem_ack = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4180 || instr_valid !== 1'b0)
         $display("FAIL pend_next: got req %b addr %h valid %b want 1 4180 0", imem_req, imem_addr, instr_valid); else n_pass++;
      end_cycle();
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      imem_ack = 1'b1;
      @(negedge clk); sb_q.push_back({32'h3000, mem_word(32'h3000)}); end_cycle();
      imem_ack = 1'b0;
      @(negedge clk); end_cycle();
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004)
         $display("FAIL mid_wait: got req %b addr %h want 1 3004", imem_req, imem_addr); else n_pass++;
      #1;
      rst = 1'b1;
      sb_q.delete();
      #1;
      n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0)
         $display("FAIL mid_rst: got req %b pc_en %b v %b instr %h pc %h want all 0", imem_req, pc_en, instr_valid, instr, instr_pc); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      imem_ack = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0)
         $display("FAIL late_ack: got req %b pc_en %b want 0 0", imem_req, pc_en); else n_pass++;
      end_cycle();
      imem_ack = 1'b0;
      @(negedge clk);
      n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000)
         $display("FAIL after_rst: got v %b req %b addr %h want 0 1 3000", instr_valid, imem_req, imem_addr); else n_pass++;
      end_cycle();
   endtask

   task automatic test_wrap();
      do_reset();
      jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
      @(negedge clk); end_cycle();
      jmp = 1'b0; imem_ack = 1'b1;
      @(negedge clk);
      n_checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_en !== 1'b1 || npc !== 32'h0)
         $display("FAIL wrap_npc: got addr %h pc_en %b npc %h want fffffffc 1 0", imem_addr, pc_en, npc); else n_pass++;
      sb_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
      end_cycle();
      imem_ack = 1'b0;
      @(negedge clk);
      n_checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", imem_addr); else n_pass++;
      end_cycle();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wait();
      test_priority();
      test_pending_exc();
      test_reset_mid_fetch();
      test_wrap();
      n_checks++;
      if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC register, instruction memory and the decode stage. Drives the PC register's `npc`/`pc_en`, runs the req/ack handshake to instruction memory, buffers one fetched instruction for decode, and applies redirects (exception, branch, jump), including redirects that arrive while a fetch is outstanding.

## Interface
- `RESET_PC`, 32'h0000_3000: reset vector; must match the PC register reset value.
- `EXC_VEC`, 32'h0000_4180: exception redirect target.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pc` in 32: current PC from the PC register.
- `npc` out 32: next PC to the PC register.
- `pc_en` out 1: PC register write enable.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: memory completes the request this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `stall_d` in 1: decode cannot accept an instruction.
- `exc` in 1: exception redirect.
- `br_taken` in 1, `br_target` in 32: branch redirect.
- `jmp` in 1, `jmp_target` in 32: jump redirect.
- `instr_valid` out 1: output buffer holds an instruction.
- `instr` out 32: buffered instruction.
- `instr_pc` out 32: address of the buffered instruction.

## Operation
- Redirect priority: `exc` (target `EXC_VEC`), then `br_taken`, then `jmp`. `redir` is the OR of the three.
- States:
  - BOOT: one cycle after reset release; no request; then IDLE.
  - IDLE: no request outstanding.
  - WAIT: request outstanding, ack not yet seen.
- `can_issue = !instr_valid || !stall_d`.
- `imem_req = (state==WAIT) || (state==IDLE && can_issue && !redir)`.
- `imem_addr = pc`. `pc` is not changed while a request is outstanding.
- Request accepted and acked, no redirect and no pending redirect:
  - Capture `imem_rdata` into `instr` and `pc` into `instr_pc`; set `instr_valid`.
  - Pulse `pc_en` with `npc = pc + 4` (mod 2^32).
  - Next state IDLE.
- Request accepted, no ack: next state WAIT; hold `imem_req` and `imem_addr` until ack.
- Redirect in IDLE:
  - `pc_en=1`, `npc` = winning target, no request this cycle.
  - Clear `instr_valid`.
- Redirect in WAIT without ack:
  - Latch the target into the pending register and clear `instr_valid`.
  - `pc` is not touched.
  - A later redirect overwrites the pending target, except that a pending `exc` is overwritten only by another `exc`.
- Ack in WAIT with a redirect in the same cycle, or with a pending redirect:
  - Discard `imem_rdata`.
  - `pc_en=1`, `npc` = that cycle's redirect target if present, else the pending target.
  - Clear the pending register; next state IDLE.
- Buffer consumption: when `instr_valid && !stall_d`, decode takes the instruction this cycle. The buffer clears unless refilled in the same cycle.
- `pc_en=0` and `npc = pc + 4` in all other cycles.

## Timing
- Reset values:
  - state BOOT; pending register empty.
  - `instr_valid=0`, `instr=0`, `instr_pc=0`.
  - `imem_req=0`, `pc_en=0`.
- First request is issued in the cycle after BOOT, with `imem_addr = RESET_PC`.
- Latency: ack in cycle N gives `instr_valid` in N+1.
- Zero-wait memory with no stalls sustains 1 instruction per cycle.
- `stall_d` held: the buffer holds its value. At most one fetch can complete while the buffer is full, because issue requires `can_issue`.
- Reset mid-fetch: everything returns to reset values immediately; a late `imem_ack` after reset release is ignored in BOOT.
- `pc + 4` wraps from 32'hFFFF_FFFC to 0.

## Structure
- Shared package `fetch_pkg`:
  - state enum {BOOT, IDLE, WAIT}
  - `RESET_PC`, `EXC_VEC` defaults
  - redirect-source encoding
- Natural sub-module: `redirect_sel`, a combinational priority mux producing `redir` and its target.

## Test plan
- Reset release, memory acks same cycle, `stall_d=0`:
  - `imem_addr` = 3000, 3004, 3008 on consecutive cycles from cycle 2.
  - `instr_pc` follows one cycle later.
- `stall_d=1` for 3 cycles with `instr_valid=1`:
  - `instr` and `instr_pc` stable.
  - `pc_en` pulses at most once.
  - Fetch resumes the cycle after `stall_d` falls.
- Request to 3008 with ack delayed 3 cycles, `br_taken` with target 3100 in wait cycle 1:
  - `imem_addr` stays 3008.
  - Returned word discarded; `npc=3100` with `pc_en` on the ack cycle; next request is to 3100.
- Same cycle `exc`, `br_taken` and `jmp`: `npc=4180`.
- Pending `exc`, then `jmp` to 3200 before the ack: redirect goes to 4180.
- `rst` asserted in WAIT, then ack arrives after release:
  - All outputs return to reset values.
  - No instruction is captured.
  - First request is to 3000.
